// File: rtl/regref_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : regref_sequencer
// Purpose  : T0..T3 instruction-cycle sequencer. Executes register-reference
//            instructions at T3 and hands all other opcodes to an external
//            executor. Optional macro: RRI_SINGLE_OP_EN (reject combined microops).
// Revision : 1.0
// ============================================================================
module regref_sequencer #(
   parameter int         AC_W      = 16,
   parameter logic [3:0] REGREF_OP = 4'b0111
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            run,
   input  logic [15:0]     IR,
   input  logic [AC_W-1:0] AC,
   input  logic            E,
   input  logic            ext_done,
   output logic [3:0]      T,
   output logic            running,
   output logic            ar_from_pc,
   output logic            ir_load,
   output logic            pc_inc,
   output logic            ar_from_ir,
   output logic            clr_ac,
   output logic            clr_e,
   output logic            com_ac,
   output logic            com_e,
   output logic            cir_ac,
   output logic            cil_ac,
   output logic            inc_ac,
   output logic            ext_start
`ifdef RRI_SINGLE_OP_EN
   ,
   output logic            illegal_op
`endif
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_T0   = 3'd1,
      S_T1   = 3'd2,
      S_T2   = 3'd3,
      S_T3   = 3'd4,
      S_WAIT = 3'd5
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_ir_q;
   logic        w_regref;
   logic        w_skip;
   logic        w_multi;

   assign w_regref = (r_ir_q[15:12] == REGREF_OP);

   // Any enabled skip condition yields one pc_inc strobe.
   assign w_skip = (r_ir_q[4] & ~AC[AC_W-1])
                 | (r_ir_q[3] &  AC[AC_W-1])
                 | (r_ir_q[2] &  (AC == '0))
                 | (r_ir_q[1] & ~E);

`ifdef RRI_SINGLE_OP_EN
   // x & (x-1) clears the lowest set bit; non-zero means two or more bits set.
   assign w_multi = |(r_ir_q[11:0] & (r_ir_q[11:0] - 12'd1));
`else
   assign w_multi = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= S_IDLE;
         r_ir_q  <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_T2) begin
            r_ir_q <= IR;
         end
      end
   end

   always_comb begin
      w_next     = r_state;
      T          = 4'b0000;
      running    = (r_state != S_IDLE);
      ar_from_pc = 1'b0;
      ir_load    = 1'b0;
      pc_inc     = 1'b0;
      ar_from_ir = 1'b0;
      clr_ac     = 1'b0;
      clr_e      = 1'b0;
      com_ac     = 1'b0;
      com_e      = 1'b0;
      cir_ac     = 1'b0;
      cil_ac     = 1'b0;
      inc_ac     = 1'b0;
      ext_start  = 1'b0;
`ifdef RRI_SINGLE_OP_EN
      illegal_op = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            if (run) begin
               w_next = S_T0;
            end
         end
         S_T0: begin
            T          = 4'b0001;
            ar_from_pc = 1'b1;
            w_next     = S_T1;
         end
         S_T1: begin
            T       = 4'b0010;
            ir_load = 1'b1;
            pc_inc  = 1'b1;
            w_next  = S_T2;
         end
         S_T2: begin
            T          = 4'b0100;
            ar_from_ir = 1'b1;
            w_next     = S_T3;
         end
         S_T3: begin
            T = 4'b1000;
            if (!w_regref) begin
               ext_start = 1'b1;
               w_next    = S_WAIT;
            end else if (w_multi) begin
`ifdef RRI_SINGLE_OP_EN
               illegal_op = 1'b1;
`endif
               w_next = S_T0;
            end else begin
               clr_ac = r_ir_q[11];
               clr_e  = r_ir_q[10];
               com_ac = r_ir_q[9];
               com_e  = r_ir_q[8];
               cir_ac = r_ir_q[7];
               cil_ac = r_ir_q[6];
               inc_ac = r_ir_q[5];
               pc_inc = w_skip;
               // HLT drops to IDLE; running falls with the state change.
               w_next = r_ir_q[0] ? S_IDLE : S_T0;
            end
         end
         S_WAIT: begin
            if (ext_done) begin
               w_next = S_T0;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_regref_sequencer.sv
`default_nettype none
// Bench for regref_sequencer: instruction-level model compared every cycle,
// plus hand-computed literal checks at the interesting points.
module tb_regref_sequencer;
   localparam int AC_W = 16;

   logic            CLK = 1'b0;
   logic            RST;
   logic            run;
   logic [15:0]     IR;
   logic [AC_W-1:0] AC;
   logic            E;
   logic            ext_done;
   logic [3:0]      T;
   logic            running, ar_from_pc, ir_load, pc_inc, ar_from_ir;
   logic            clr_ac, clr_e, com_ac, com_e, cir_ac, cil_ac, inc_ac;
   logic            ext_start;
   logic            ill;

   regref_sequencer #(.AC_W(AC_W), .REGREF_OP(4'b0111)) dut (
      .CLK(CLK), .RST(RST), .run(run), .IR(IR), .AC(AC), .E(E),
      .ext_done(ext_done), .T(T), .running(running),
      .ar_from_pc(ar_from_pc), .ir_load(ir_load), .pc_inc(pc_inc),
      .ar_from_ir(ar_from_ir), .clr_ac(clr_ac), .clr_e(clr_e),
      .com_ac(com_ac), .com_e(com_e), .cir_ac(cir_ac), .cil_ac(cil_ac),
      .inc_ac(inc_ac), .ext_start(ext_start)
`ifdef RRI_SINGLE_OP_EN
      , .illegal_op(ill)
`endif
   );
`ifndef RRI_SINGLE_OP_EN
   assign ill = 1'b0;
`endif

   always #5 CLK = ~CLK;

   int checks   = 0;
   int failures = 0;
   bit en       = 1'b0;

   // Model: phase 0=idle, 1..4 = T0..T3, 5 = waiting on the executor.
   int          m_phase = 0;
   logic [15:0] m_ir    = '0;

   function automatic logic is_rr(input logic [15:0] ir);
      return ir[15:12] == 4'd7;
   endfunction

   function automatic logic rr_legal(input logic [15:0] ir);
`ifdef RRI_SINGLE_OP_EN
      return $countones(ir[11:0]) <= 1;
`else
      return 1'b1;
`endif
   endfunction

   always @(posedge CLK) begin
      if (RST) begin
         m_phase <= 0;
         m_ir    <= '0;
      end else begin
         case (m_phase)
            0: if (run) m_phase <= 1;
            1, 2: m_phase <= m_phase + 1;
            3: begin
               m_ir    <= IR;
               m_phase <= 4;
            end
            4: begin
               if (!is_rr(m_ir))                      m_phase <= 5;
               else if (rr_legal(m_ir) && m_ir[0])    m_phase <= 0;
               else                                   m_phase <= 1;
            end
            default: if (ext_done) m_phase <= 1;
         endcase
      end
   end

   // Expected {T, running, ar_from_pc, ir_load, pc_inc, ar_from_ir,
   //           clr_ac..inc_ac, ext_start, illegal_op}.
   function automatic logic [17:0] expect_out(input int ph, input logic [15:0] ir,
                                              input logic [15:0] ac, input logic e);
      logic [17:0] v;
      logic        ex;
      logic        skip;
      v    = '0;
      ex   = (ph == 4) && is_rr(ir) && rr_legal(ir);
      skip = (ir[4] && ac < 16'h8000) || (ir[3] && ac >= 16'h8000) ||
             (ir[2] && ac == 16'h0000) || (ir[1] && !e);
      if (ph >= 1 && ph <= 4) v[17:14] = 4'(1 << (ph - 1));
      v[13]  = (ph != 0);
      v[12]  = (ph == 1);
      v[11]  = (ph == 2);
      v[10]  = (ph == 2) || (ex && skip);
      v[9]   = (ph == 3);
      v[8:2] = ex ? ir[11:5] : 7'b0;
      v[1]   = (ph == 4) && !is_rr(ir);
      v[0]   = (ph == 4) && is_rr(ir) && !rr_legal(ir);
      return v;
   endfunction

   task automatic model_compare();
      logic [17:0] got;
      logic [17:0] exp;
      got = {T, running, ar_from_pc, ir_load, pc_inc, ar_from_ir,
             clr_ac, clr_e, com_ac, com_e, cir_ac, cil_ac, inc_ac, ext_start, ill};
      exp = expect_out(m_phase, m_ir, AC, E);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL model_cycle t=%0t phase=%0d got=%05h expected=%05h",
                  $time, m_phase, got, exp);
      end
   endtask

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   // Advance one clock; outputs are compared 2 time units after the edge,
   // before the bench drives new inputs.
   task automatic step();
      @(posedge CLK);
      #2;
      if (en) model_compare();
   endtask

   // From T0: present an instruction and advance to its T3.
   task automatic run_to_t3(input logic [15:0] ir);
      IR = ir;
      step();
      step();
      step();
   endtask

   initial begin
      RST = 1'b1; run = 1'b0; IR = '0; AC = '0; E = 1'b0; ext_done = 1'b0;
      step();
      step();
      en = 1'b1;
      chk("rst_T", 16'(T), 16'h0);
      chk("rst_running", 16'(running), 16'h0);
      chk("rst_ext_start", 16'(ext_start), 16'h0);

      RST = 1'b0; run = 1'b1; IR = 16'h7800; AC = 16'h1234; E = 1'b1;
      step();
      chk("c1_T", 16'(T), 16'h1);
      chk("c1_ar_from_pc", 16'(ar_from_pc), 16'h1);
      run = 1'b0;
      step();
      chk("c2_T", 16'(T), 16'h2);
      chk("c2_ir_load", 16'(ir_load), 16'h1);
      chk("c2_pc_inc", 16'(pc_inc), 16'h1);
      step();
      chk("c3_T", 16'(T), 16'h4);
      chk("c3_ar_from_ir", 16'(ar_from_ir), 16'h1);
      step();
      chk("cla_T", 16'(T), 16'h8);
      chk("cla_clr_ac", 16'(clr_ac), 16'h1);
      chk("cla_com_ac", 16'(com_ac), 16'h0);
      chk("cla_pc_inc", 16'(pc_inc), 16'h0);
      step();
      chk("cla_next_T0", 16'(T), 16'h1);

      run_to_t3(16'h7A00);
`ifdef RRI_SINGLE_OP_EN
      chk("cla_cma_clr_ac", 16'(clr_ac), 16'h0);
      chk("cla_cma_com_ac", 16'(com_ac), 16'h0);
      chk("cla_cma_illegal", 16'(ill), 16'h1);
`else
      chk("cla_cma_clr_ac", 16'(clr_ac), 16'h1);
      chk("cla_cma_com_ac", 16'(com_ac), 16'h1);
`endif
      step();

      AC = 16'h0000;
      run_to_t3(16'h7004);
      chk("sza_zero_pc_inc", 16'(pc_inc), 16'h1);
      step();
      AC = 16'h0001;
      run_to_t3(16'h7004);
      chk("sza_nonzero_pc_inc", 16'(pc_inc), 16'h0);
      step();
      AC = 16'h8000;
      run_to_t3(16'h7010);
      chk("spa_neg_pc_inc", 16'(pc_inc), 16'h0);
      step();
      AC = 16'h0001; E = 1'b0;
      run_to_t3(16'h7006);
      step();
      AC = 16'h0000;
      run_to_t3(16'h701E);
      step();
      AC = 16'hF00F; E = 1'b1;
      run_to_t3(16'h74E0);
      step();
      run_to_t3(16'h7008);
      chk("sna_neg_pc_inc", 16'(pc_inc), 16'h1);
      step();

      run = 1'b1;
      IR = 16'h7001;
      step();
      step();
      run = 1'b0;
      step();
      chk("hlt_T", 16'(T), 16'h8);
      chk("hlt_running", 16'(running), 16'h1);
      step();
      chk("hlt_idle_T", 16'(T), 16'h0);
      chk("hlt_idle_running", 16'(running), 16'h0);
      step();
      chk("hlt_stays_idle", 16'(running), 16'h0);
      run = 1'b1;
      step();
      chk("restart_T0", 16'(T), 16'h1);
      run = 1'b0;

      AC = 16'h0000; E = 1'b0;
      run_to_t3(16'h2123);
      chk("mri_ext_start", 16'(ext_start), 16'h1);
      chk("mri_clr_ac", 16'(clr_ac), 16'h0);
      chk("mri_pc_inc", 16'(pc_inc), 16'h0);
      ext_done = 1'b1;
      step();
      ext_done = 1'b0;
      chk("wait_T", 16'(T), 16'h0);
      chk("wait_running", 16'(running), 16'h1);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("wait_hold_T", 16'(T), 16'h0);
      end
      ext_done = 1'b1;
      step();
      chk("done_T0", 16'(T), 16'h1);
      ext_done = 1'b0;

      run_to_t3(16'h0000);
      chk("op0_ext_start", 16'(ext_start), 16'h1);
      step();
      ext_done = 1'b1;
      step();
      chk("op0_done_T0", 16'(T), 16'h1);
      ext_done = 1'b0;

      IR = 16'h7800;
      step();
      step();
      chk("pre_rst_T2", 16'(T), 16'h4);
      RST = 1'b1;
      step();
      RST = 1'b0;
      chk("rst_t2_T", 16'(T), 16'h0);
      chk("rst_t2_running", 16'(running), 16'h0);
      chk("rst_t2_ar_from_ir", 16'(ar_from_ir), 16'h0);

      run = 1'b1;
      step();
      run = 1'b0;
      run_to_t3(16'h3456);
      step();
      chk("pre_rst_wait_running", 16'(running), 16'h1);
      RST = 1'b1;
      step();
      RST = 1'b0;
      chk("rst_wait_running", 16'(running), 16'h0);
      ext_done = 1'b1;
      step();
      chk("rst_wait_done_T", 16'(T), 16'h0);
      chk("rst_wait_done_running", 16'(running), 16'h0);
      ext_done = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/regref_sequencer.md
Name: regref_sequencer

Overview:
Timing and control sequencer for the basic-computer instruction cycle. Steps one-hot timing states T0..T3, issues the fetch/decode strobes, and executes register-reference instructions at T3 as single-cycle microoperation strobes to the AC/E datapath. Handles skip-on-condition and HLT itself. Hands every other instruction (memory-reference, I/O) to an external executor through a start/done handshake. Sits between the IR/PC/AR registers and the AC/E register file.

Parameters:
AC_W, 16, accumulator width; the skip tests operate on AC[AC_W-1:0].
REGREF_OP, 4'b0111, IR[15:12] value that identifies a register-reference instruction.

Ports:
CLK  in  1  system clock; all state changes on rising edge
RST  in  1  synchronous, active-high reset
run  in  1  start request; sampled only in IDLE
IR  in  16  instruction register contents; valid from the cycle after ir_load
AC  in  AC_W  accumulator value, for skip tests
E  in  1  carry/extend flip-flop, for SZE
ext_done  in  1  external executor finished; sampled only in WAIT
T  out  4  one-hot timing: T[0]=T0 .. T[3]=T3; 0 in IDLE/WAIT
running  out  1  S flip-flop; 1 in every state except IDLE
ar_from_pc  out  1  load AR<-PC (T0)
ir_load  out  1  load IR<-M[AR] (T1)
pc_inc  out  1  PC increment (T1, or skip at T3)
ar_from_ir  out  1  load AR<-IR[11:0] (T2)
clr_ac, clr_e, com_ac, com_e, cir_ac, cil_ac, inc_ac  out  1 each  AC/E microoperation strobes (T3)
ext_start  out  1  one-cycle dispatch pulse to the external executor

Behaviour:
- States: IDLE, T0, T1, T2, T3, WAIT. Registered state; outputs are decoded from the state and the latched IR (ir_q). Each strobe is high for exactly one cycle.
- Reset: state=IDLE, ir_q=0, running=0, all strobes and T are 0 in the cycle after RST is sampled high. RST takes priority over everything, including mid-instruction and WAIT.
- IDLE: run=1 -> T0 next cycle. run is ignored in all other states.
- T0: ar_from_pc=1 -> T1.
- T1: ir_load=1, pc_inc=1 -> T2.
- T2: ar_from_ir=1; ir_q<=IR at this edge -> T3.
- T3, ir_q[15:12]==REGREF_OP (register reference). Every set bit acts in the same cycle (combined microops are legal):
  - b11 clr_ac, b10 clr_e, b9 com_ac, b8 com_e, b7 cir_ac, b6 cil_ac, b5 inc_ac.
  - Skip: pc_inc=1 if any enabled condition holds: b4 SPA (AC[AC_W-1]==0), b3 SNA (AC[AC_W-1]==1), b2 SZA (AC==0), b1 SZE (E==0). pc_inc is a single strobe even when several conditions hold.
  - b0 HLT: running cleared, next state IDLE; strobes from the other bits still fire this cycle.
  - Without HLT, next state is T0.
- T3, any other opcode: ext_start=1 for one cycle, no AC/E strobes -> WAIT.
- WAIT: all strobes 0. ext_done=1 -> T0 next cycle; otherwise stay. ext_done is ignored outside WAIT, so a done pulse coincident with ext_start has no effect.
- ir_q==0 at T3 is not register-reference (opcode 0000): it dispatches to the external executor.
- Latency: run to first T3 is 4 cycles; register-reference instruction period is 4 cycles.

Optional Feature:
Macro RRI_SINGLE_OP_EN.
- Defined: at T3 for a register-reference instruction, if more than one of ir_q[11:0] is set, no microop strobes, no pc_inc, and no HLT action; next state is T0. Output illegal_op (1 bit) pulses high for that one cycle.
- Not defined: combined bits execute concurrently as specified above. illegal_op port is absent.

Test Plan:
- Reset then run=1 at cycle 0 -> T=0001 at cycle 1, 0010 at 2, 0100 at 3, 1000 at 4. ar_from_pc at 1; ir_load and pc_inc at 2; ar_from_ir at 3.
- IR=16'h7800 (CLA) -> clr_ac=1 only at T3, pc_inc=0, T0 follows. IR=16'h7A00 (CLA+CMA) -> clr_ac and com_ac both 1 at T3; with RRI_SINGLE_OP_EN, instead no strobes and illegal_op=1.
- IR=16'h7004 (SZA): AC=0 -> pc_inc=1 at T3; AC=16'h0001 -> pc_inc=0. IR=16'h7010 (SPA) with AC=16'h8000 -> pc_inc=0.
- IR=16'h7001 (HLT) -> at T3, running stays 1; next cycle state=IDLE, running=0, T=0. run=1 then restarts at T0.
- IR=16'h2123 (memory-reference) -> ext_start=1 at T3. Hold ext_done=0 for 5 cycles -> T=0 throughout. ext_done=1 -> T0 next cycle.
- RST asserted during T2 and again during WAIT -> IDLE next cycle, all outputs 0, later ext_done ignored.
